// File: rtl/mux41_pkg.sv
// Shared constants for the registered 4:1 data multiplexer.
// Select encodings are common to RTL and bench.
package mux41_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0 = 2'd0;
  localparam sel_t SEL_D1 = 2'd1;
  localparam sel_t SEL_D2 = 2'd2;
  localparam sel_t SEL_D3 = 2'd3;

endpackage

// File: rtl/mux41_if_core.sv
// Combinational 4:1 selector using an if/else-if chain.
// The final else covers code 3, so every select value is defined.
module mux41_if_core
  import mux41_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEFAULT
) (
  input  logic [WIDTH-1:0] d_0,
  input  logic [WIDTH-1:0] d_1,
  input  logic [WIDTH-1:0] d_2,
  input  logic [WIDTH-1:0] d_3,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d_3;
    if (sel == SEL_D0) begin
      y = d_0;
    end else if (sel == SEL_D1) begin
      y = d_1;
    end else if (sel == SEL_D2) begin
      y = d_2;
    end else begin
      y = d_3;
    end
  end

endmodule

// File: rtl/mux41_if_sync.sv
// Registered 4:1 mux: selected data, select and valid are
// captured together so the outputs always describe one sample.
module mux41_if_sync
  import mux41_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d_0,
  input  logic [WIDTH-1:0] i_d_1,
  input  logic [WIDTH-1:0] i_d_2,
  input  logic [WIDTH-1:0] i_d_3,
  input  logic [1:0]       i_sel,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_y,
  output logic [1:0]       o_sel,
  output logic             o_valid
);

  logic [WIDTH-1:0] y_next;

  mux41_if_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .d_0(i_d_0),
    .d_1(i_d_1),
    .d_2(i_d_2),
    .d_3(i_d_3),
    .sel(i_sel),
    .y  (y_next)
  );

  // Valid travels alongside the data; it never gates the data path.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_y     <= '0;
      o_sel   <= SEL_D0;
      o_valid <= 1'b0;
    end else begin
      o_y     <= y_next;
      o_sel   <= i_sel;
      o_valid <= i_valid;
    end
  end

endmodule

// File: tb/tb_mux41_if_sync.sv
// Directed-vector bench for mux41_if_sync.
// Each step drives inputs, takes one edge and checks all outputs.
module tb_mux41_if_sync;
  import mux41_pkg::*;

  localparam int W = DATA_W_DEFAULT;

  logic         clk;
  logic         rst;
  logic [W-1:0] d_0;
  logic [W-1:0] d_1;
  logic [W-1:0] d_2;
  logic [W-1:0] d_3;
  logic [1:0]   sel;
  logic         valid;
  logic [W-1:0] y;
  logic [1:0]   y_sel;
  logic         y_valid;

  int checks;
  int failures;

  mux41_if_sync #(
    .WIDTH(W)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_d_0  (d_0),
    .i_d_1  (d_1),
    .i_d_2  (d_2),
    .i_d_3  (d_3),
    .i_sel  (sel),
    .i_valid(valid),
    .o_y    (y),
    .o_sel  (y_sel),
    .o_valid(y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample, take one edge, check outputs 1 ns later.
  task automatic step(input string tag,
                      input logic r,
                      input logic [W-1:0] a0,
                      input logic [W-1:0] a1,
                      input logic [W-1:0] a2,
                      input logic [W-1:0] a3,
                      input logic [1:0] s,
                      input logic v,
                      input logic [W-1:0] ey,
                      input logic [1:0] es,
                      input logic ev);
    rst   = r;
    d_0   = a0;
    d_1   = a1;
    d_2   = a2;
    d_3   = a3;
    sel   = s;
    valid = v;
    @(posedge clk);
    #1;
    chk({tag, ".y"}, y, ey);
    chk({tag, ".sel"}, {6'd0, y_sel}, {6'd0, es});
    chk({tag, ".valid"}, {7'd0, y_valid}, {7'd0, ev});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    d_0   = '0;
    d_1   = '0;
    d_2   = '0;
    d_3   = '0;
    sel   = SEL_D0;
    valid = 1'b0;
    #2;

    step("rst0", 1, 8'hAA, 8'hBB, 8'hCC, 8'hDD, SEL_D3, 1, 8'h00, SEL_D0, 0);
    step("rst1", 1, 8'h11, 8'h22, 8'h33, 8'h44, SEL_D2, 1, 8'h00, SEL_D0, 0);
    step("rel",  0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D0, 1, 8'd0, SEL_D0, 1);

    step("sw0a", 0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D0, 1, 8'd0, SEL_D0, 1);
    step("sw1a", 0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D1, 1, 8'd1, SEL_D1, 1);
    step("sw1b", 0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D1, 1, 8'd1, SEL_D1, 1);
    step("sw2a", 0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D2, 1, 8'd2, SEL_D2, 1);
    step("sw2b", 0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D2, 1, 8'd2, SEL_D2, 1);
    step("sw3a", 0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D3, 1, 8'd3, SEL_D3, 1);
    step("sw3b", 0, 8'd0, 8'd1, 8'd2, 8'd3, SEL_D3, 1, 8'd3, SEL_D3, 1);

    step("dc4",  0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D0, 1, 8'd4, SEL_D0, 1);
    step("dc5",  0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D1, 1, 8'd5, SEL_D1, 1);
    step("dc6",  0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D2, 1, 8'd6, SEL_D2, 1);
    step("dc7",  0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D3, 1, 8'd7, SEL_D3, 1);
    step("dc8",  0, 8'd8, 8'd9, 8'd10, 8'd11, SEL_D0, 1, 8'd8, SEL_D0, 1);
    step("dc9",  0, 8'd8, 8'd9, 8'd10, 8'd11, SEL_D1, 1, 8'd9, SEL_D1, 1);
    step("dc10", 0, 8'd8, 8'd9, 8'd10, 8'd11, SEL_D2, 1, 8'd10, SEL_D2, 1);
    step("dc11", 0, 8'd8, 8'd9, 8'd10, 8'd11, SEL_D3, 1, 8'd11, SEL_D3, 1);

    step("fwFF", 0, 8'h00, 8'hFF, 8'hA5, 8'h5A, SEL_D1, 1, 8'hFF, SEL_D1, 1);
    step("fwA5", 0, 8'h00, 8'hFF, 8'hA5, 8'h5A, SEL_D2, 1, 8'hA5, SEL_D2, 1);
    step("fw5A", 0, 8'h00, 8'hFF, 8'hA5, 8'h5A, SEL_D3, 1, 8'h5A, SEL_D3, 1);
    step("fw00", 0, 8'h00, 8'hFF, 8'hA5, 8'h5A, SEL_D0, 1, 8'h00, SEL_D0, 1);

    step("mrpre", 0, 8'd8, 8'd9, 8'd10, 8'd11, SEL_D3, 1, 8'd11, SEL_D3, 1);
    step("mrrst", 1, 8'd8, 8'd9, 8'd10, 8'd11, SEL_D3, 1, 8'd0, SEL_D0, 0);
    step("mrrel", 0, 8'd8, 8'd9, 8'd10, 8'd11, SEL_D3, 1, 8'd11, SEL_D3, 1);

    step("vi0", 0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D2, 0, 8'd6, SEL_D2, 0);
    step("vt1", 0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D2, 1, 8'd6, SEL_D2, 1);
    step("vt2", 0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D1, 0, 8'd5, SEL_D1, 0);
    step("vt3", 0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D0, 1, 8'd4, SEL_D0, 1);
    step("vt4", 0, 8'd4, 8'd5, 8'd6, 8'd7, SEL_D3, 0, 8'd7, SEL_D3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
